// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the MIPS instruction encoder/loader.
// Covers symbolic op numbering, opcode/funct constants, FSM states and word-builder helpers.
package instr_enc_pkg;

  // Codes 0..20 line up with the decode controller's alu_code numbering
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_NOR   = 5'd6,
    OP_SLT   = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_JR    = 5'd11,
    OP_NOP   = 5'd12,
    OP_ANDI  = 5'd13,
    OP_ORI   = 5'd14,
    OP_SLTI  = 5'd15,
    OP_ADDI  = 5'd16,
    OP_ADDIU = 5'd17,
    OP_LW    = 5'd18,
    OP_SW    = 5'd19,
    OP_LUI   = 5'd20,
    OP_J     = 5'd21,
    OP_JAL   = 5'd22,
    OP_BEQ   = 5'd23,
    OP_BNE   = 5'd24
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Op/field stream from a program source into the encoder, with valid/ready/last handshake.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  op_code;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, in_last, op_code, rs, rt, rd, shamt, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, op_code, rs, rt, rd, shamt, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader_word_encode.sv
// Combinational builder: symbolic op plus fields -> 32-bit MIPS word and a legality flag.
module instr_word_encode
  import instr_enc_pkg::*;
(
  input  logic [4:0]  i_op_code,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  op_e w_op;
  assign w_op = op_e'(i_op_code);

  // Unused fields are forced to zero so the word is canonical (e.g. rs of shifts and lui)
  always_comb begin
    o_word  = 32'h0000_0000;
    o_legal = 1'b1;
    case (w_op)
      OP_ADD:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_ADD);
      OP_ADDU:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_ADDU);
      OP_SUB:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_SUB);
      OP_SUBU:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_SUBU);
      OP_AND:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_AND);
      OP_OR:    o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_OR);
      OP_NOR:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_NOR);
      OP_SLT:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, FN_SLT);
      OP_SLL:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, FN_SLL);
      OP_SRL:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, FN_SRL);
      OP_SRA:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, FN_SRA);
      OP_JR:    o_word = r_word(i_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_NOP:   o_word = 32'h0000_0000;
      OP_ANDI:  o_word = i_word(OPC_ANDI, i_rs, i_rt, i_imm);
      OP_ORI:   o_word = i_word(OPC_ORI, i_rs, i_rt, i_imm);
      OP_SLTI:  o_word = i_word(OPC_SLTI, i_rs, i_rt, i_imm);
      OP_ADDI:  o_word = i_word(OPC_ADDI, i_rs, i_rt, i_imm);
      OP_ADDIU: o_word = i_word(OPC_ADDIU, i_rs, i_rt, i_imm);
      OP_LW:    o_word = i_word(OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:    o_word = i_word(OPC_SW, i_rs, i_rt, i_imm);
      OP_LUI:   o_word = i_word(OPC_LUI, 5'd0, i_rt, i_imm);
      OP_J:     o_word = j_word(OPC_J, i_target);
      OP_JAL:   o_word = j_word(OPC_JAL, i_target);
      OP_BEQ:   o_word = i_word(OPC_BEQ, i_rs, i_rt, i_imm);
      OP_BNE:   o_word = i_word(OPC_BNE, i_rs, i_rt, i_imm);
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes a stream of symbolic ops and writes them sequentially into
// instruction memory from BASE_ADDR, through a single pipeline register.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  imem_wen,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_W:0]       count,
  output logic                  done,
  output logic                  error
);

  localparam int FILL_W = ADDR_W + 2;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_ptr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_error;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_ready;
  logic                w_done;
  logic                w_accept;
  logic                w_overflow;
  logic [FILL_W-1:0]   w_fill;

  instr_word_encode u_encode (
    .i_op_code (bus.op_code),
    .i_rs      (bus.rs),
    .i_rt      (bus.rt),
    .i_rd      (bus.rd),
    .i_shamt   (bus.shamt),
    .i_imm     (bus.imm),
    .i_target  (bus.target),
    .o_word    (w_word),
    .o_legal   (w_legal)
  );

  // Words already written plus the one sitting in the pipeline register
  assign w_fill     = FILL_W'(r_count) + FILL_W'(r_wen);
  assign w_accept   = bus.in_valid && w_ready;
  assign w_overflow = (r_state == ST_LOAD) && bus.in_valid && !w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = (w_fill < FILL_W'(DEPTH));
        if (bus.in_valid && (!w_ready || bus.in_last)) begin
          w_state_next = ST_FLUSH;
        end
      end
      // Nothing is accepted here, so the single pipeline stage empties on this edge
      ST_FLUSH: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_ptr   <= ADDR_W'(BASE_ADDR);
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_wen   <= w_accept && w_legal;
      r_count <= r_count + (ADDR_W+1)'(r_wen);
      if (w_accept && w_legal) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_ptr   <= r_ptr + 1'b1;
      end
      if ((w_accept && !w_legal) || w_overflow) begin
        r_error <= 1'b1;
      end
      // Pipeline is always empty in IDLE, so restarting the counters here is safe
      if ((r_state == ST_IDLE) && start) begin
        r_count <= '0;
        r_error <= 1'b0;
        r_ptr   <= ADDR_W'(BASE_ADDR);
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign imem_wen     = r_wen;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign count        = r_count;
  assign done         = w_done;
  assign error        = r_error;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the MIPS instruction-decode controller.
- Accepts symbolic operations as an op code plus register and immediate fields, and builds the 32-bit MIPS instruction word.
- Writes each word sequentially into instruction memory under a valid/ready handshake, starting at a base address.
- Used by test harnesses and the boot path to load programs without a precompiled image.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of words that may be loaded (at most 2^ADDR_W).
- BASE_ADDR, 0, first imem word address written.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a load session (sampled in IDLE only).
- in_valid  in  1  op/fields presented.
- in_ready  out  1  encoder can accept this cycle.
- in_last  in  1  final instruction of the session (qualified by in_valid).
- op_code  in  5  operation, numbered per the shared package.
- rs  in  5  source register field.
- rt  in  5  second source or destination register field.
- rd  in  5  destination register field.
- shamt  in  5  shift amount.
- imm  in  16  immediate or branch offset.
- target  in  26  jump target field.
- imem_wen  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- done  out  1  one-cycle pulse at session end.
- error  out  1  sticky: illegal op or overflow this session.

Behaviour:
- Reset: state IDLE; every output is 0, including imem_addr and imem_wdata.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: in_ready=0. On start, go to LOAD, set count=0, clear error, set the write pointer to BASE_ADDR.
  - LOAD: in_ready=1 while count+pending < DEPTH. A transfer occurs when in_valid&&in_ready.
  - FLUSH: entered after accepting in_last, or on overflow. in_ready=0. Waits for the pipeline stage to drain, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: an op accepted at edge N appears as imem_wen=1 with addr/wdata during cycle N+1. There is one pipeline register. Back-to-back accepts give one write per cycle.
- Address and count: the pointer increments once per write. count equals the number of writes. No wrap: addresses run BASE_ADDR to BASE_ADDR+DEPTH-1.
- Overflow: if in_valid arrives in LOAD with count+pending == DEPTH:
  - the op is not accepted;
  - error is set;
  - the FSM goes to FLUSH.
- Illegal op_code (25..31):
  - the op is accepted, but no write, no pointer or count increment;
  - error is set and the session continues;
  - if in_last is set, the FSM still ends the session.
- Encoding (fields not listed are zero):
  - R-type: op=000000, rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
  - Funct values: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, nor 100111, slt 101010.
  - sll 000000, srl 000010, sra 000011; for these rs=0.
  - jr: rs only, funct 001000.
  - nop: 0x00000000.
  - I-type opcodes: andi 001100, ori 001101, slti 001010, addi 001000, addiu 001001, lw 100011, sw 101011, lui 001111 (rs=0), beq 000100, bne 000101.
  - I-type layout: rs, rt, imm[15:0].
  - J-type: j 000010, jal 000011, target[25:0].
- start while not IDLE: ignored.
- rst mid-session: next edge returns to IDLE. No write occurs, imem_wen=0, and the pending word is discarded.

Decomposition:
- Package instr_enc_pkg holds:
  - op_code enumeration: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 nor, 7 slt, 8 sll, 9 srl, 10 sra, 11 jr, 12 nop, 13 andi, 14 ori, 15 slti, 16 addi, 17 addiu, 18 lw, 19 sw, 20 lui, 21 j, 22 jal, 23 beq, 24 bne. Codes 0–20 match the controller's alu_code numbering.
  - MIPS opcode and funct constants.
  - FSM state type.
- Sub-module instr_word_encode: purely combinational op/fields to {word, legal}. It is instantiated once in front of the pipeline register.

Test Plan:
- start, then add rs=1 rt=2 rd=3 with in_last -> next cycle imem_wen=1, addr=0, wdata=0x00221820; count=1; done pulses 2 cycles after accept; error=0.
- Stream sll rd=2 rt=1 shamt=4, addi rs=1 rt=2 imm=5, lui rt=4 imm=0x1234, j target=0x10 back-to-back -> consecutive writes 0x00011100, 0x20220005, 0x3C041234, 0x08000010 at addrs 0..3; in_ready held 1.
- sw rs=29 rt=8 imm=4, then op_code=27, then nop with in_last -> writes 0xAFA80004 @0 and 0x00000000 @1; error=1; count=2.
- DEPTH=4, supply 5 ops with in_valid held -> 4 writes, 5th not accepted (in_ready=0), error=1, done pulse, count=4.
- rst asserted the cycle after accept -> imem_wen stays 0, state IDLE, count=0, error=0, done=0.
- start asserted during LOAD -> no effect; pointer and count continue uninterrupted.
